// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer for the didactic RISC-V core.
//
// Holds the architectural PC. Runs one instruction at a time through
// FETCH -> DISPATCH -> EXEC, then commits the branch unit's next PC.
// A misaligned commit target or a fetch that is never acknowledged raises a
// sticky trap. Only reset leaves the trap state.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   en                  run enable, sampled at instruction boundaries
//   imem_req/addr       fetch request (held until ack) and address (= pc)
//   imem_ack/rdata      fetch acknowledge with same-cycle instruction word
//   instr, instr_valid  latched instruction and one-cycle dispatch pulse
//   pc                  current PC, feeds the branch unit
//   exec_done/br_new_pc execute finished; next PC from the branch unit
//   retire, instret     commit pulse and retired-instruction counter
//   halted              high while idle or trapped
//   trap/_cause/_pc     sticky fault flag, cause (01 misaligned, 10 timeout),
//                       and PC of the faulting instruction
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   input  logic        exec_done,
   input  logic [31:0] br_new_pc,
   output logic        retire,
   output logic [31:0] instret,
   output logic        halted,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] trap_pc
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDispatch,
      StExec,
      StTrap
   } state_e;

   localparam logic [1:0] CauseNone      = 2'b00;
   localparam logic [1:0] CauseMisalign  = 2'b01;
   localparam logic [1:0] CauseTimeout   = 2'b10;

   state_e      state;
   logic [31:0] tmo_cnt;

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= StIdle;
         pc          <= RESET_VECTOR;
         imem_req    <= 1'b0;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         retire      <= 1'b0;
         instret     <= 32'h0;
         halted      <= 1'b1;
         trap        <= 1'b0;
         trap_cause  <= CauseNone;
         trap_pc     <= 32'h0;
         tmo_cnt     <= 32'h0;
      end else begin
         // Pulses last exactly one cycle unless re-armed below.
         instr_valid <= 1'b0;
         retire      <= 1'b0;

         unique case (state)
            StIdle: begin
               if (en) begin
                  state    <= StFetch;
                  imem_req <= 1'b1;
                  halted   <= 1'b0;
                  tmo_cnt  <= 32'h0;
               end
            end

            StFetch: begin
               if (imem_ack) begin
                  // An ack always wins over a timeout in the same cycle.
                  instr       <= imem_rdata;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= StDispatch;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
                  // tmo_cnt counts earlier misses, so this is the N-th miss.
                  if ((MEM_TIMEOUT != 0) && (tmo_cnt == MEM_TIMEOUT - 32'd1)) begin
                     state      <= StTrap;
                     imem_req   <= 1'b0;
                     halted     <= 1'b1;
                     trap       <= 1'b1;
                     trap_cause <= CauseTimeout;
                     trap_pc    <= pc;
                  end
               end
            end

            StDispatch: begin
               state <= StExec;
            end

            StExec: begin
               if (exec_done) begin
                  if (br_new_pc[1:0] != 2'b00) begin
                     state      <= StTrap;
                     halted     <= 1'b1;
                     trap       <= 1'b1;
                     trap_cause <= CauseMisalign;
                     trap_pc    <= pc;
                  end else begin
                     pc      <= br_new_pc;
                     retire  <= 1'b1;
                     instret <= instret + 32'd1;
                     if (en) begin
                        state    <= StFetch;
                        imem_req <= 1'b1;
                        tmo_cnt  <= 32'h0;
                     end else begin
                        state  <= StIdle;
                        halted <= 1'b1;
                     end
                  end
               end
            end

            StTrap: begin
               // Sticky: only reset leaves this state.
            end

            default: begin
               state    <= StIdle;
               imem_req <= 1'b0;
               halted   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a vector table of instructions plus
// hand-written sequences for trap, timeout, halt/resume, reset and wrap.
// Dispatched instructions and retire results are checked through queues.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic        exec_done;
   logic [31:0] br_new_pc;
   logic        retire;
   logic [31:0] instret;
   logic        halted;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;

   pc_sequencer #(
      .RESET_VECTOR (RV),
      .MEM_TIMEOUT  (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .exec_done   (exec_done),
      .br_new_pc   (br_new_pc),
      .retire      (retire),
      .instret     (instret),
      .halted      (halted),
      .trap        (trap),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_instr_q[$];
   logic [63:0] exp_ret_q[$];   // {pc, instret} expected at each retire

   typedef struct {
      logic [31:0] addr;     // expected fetch address
      logic [31:0] rdata;
      int          ack_dly;
      int          exec_dly;
      logic [31:0] new_pc;
      logic [31:0] instret;  // expected count after retire
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every dispatch / retire pulse must match a queued expectation.
   always @(negedge clk) begin
      if (instr_valid) begin
         if (exp_instr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dispatch: unexpected instr_valid, instr %h, expected none", instr);
         end else begin
            check("dispatch instr", instr, exp_instr_q.pop_front());
         end
      end
      if (retire) begin
         if (exp_ret_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL retire: unexpected pulse at pc %h, expected none", pc);
         end else begin
            logic [63:0] r;
            r = exp_ret_q.pop_front();
            check("retire pc", pc, r[63:32]);
            check("retire instret", instret, r[31:0]);
         end
      end
   end

   task automatic wait_req();
      int i = 0;
      while (!imem_req && i < 50) begin
         @(negedge clk);
         i++;
      end
      check("imem_req wait", {31'h0, imem_req}, 32'h1);
   endtask

   // Returns at the negedge of the DISPATCH cycle.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata, input int ack_dly);
      wait_req();
      check("imem_addr", imem_addr, addr);
      repeat (ack_dly) @(negedge clk);
      check("imem_req held", {31'h0, imem_req}, 32'h1);
      check("imem_addr held", imem_addr, addr);
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      exp_instr_q.push_back(rdata);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
   endtask

   // Returns at the negedge right after the exec_done edge.
   task automatic do_exec(input logic [31:0] npc, input int exec_dly, input logic en_after,
                          input logic [31:0] exp_instret, input logic [31:0] exp_instr);
      @(negedge clk);
      repeat (exec_dly) @(negedge clk);
      check("instr stable", instr, exp_instr);
      exec_done = 1'b1;
      br_new_pc = npc;
      en        = en_after;
      if (npc[1:0] == 2'b00) exp_ret_q.push_back({npc, exp_instret});
      @(negedge clk);
      exec_done = 1'b0;
      br_new_pc = 32'h0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en        = 1'b0;
      imem_ack  = 1'b0;
      exec_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic req_seen;

      vecs[0] = '{addr: 32'h00, rdata: 32'h0050_0093, ack_dly: 0, exec_dly: 0,
                  new_pc: 32'h04, instret: 32'd1};
      vecs[1] = '{addr: 32'h04, rdata: 32'h0010_0113, ack_dly: 2, exec_dly: 1,
                  new_pc: 32'h10, instret: 32'd2};
      vecs[2] = '{addr: 32'h10, rdata: 32'hFE00_0EE3, ack_dly: 0, exec_dly: 3,
                  new_pc: 32'h0C, instret: 32'd3};
      vecs[3] = '{addr: 32'h0C, rdata: 32'h0000_0013, ack_dly: 1, exec_dly: 0,
                  new_pc: 32'h20, instret: 32'd4};

      rst_n      = 1'b0;
      en         = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      exec_done  = 1'b0;
      br_new_pc  = 32'h0;
      repeat (2) @(negedge clk);

      check("reset imem_req", {31'h0, imem_req}, 32'h0);
      check("reset pc", pc, RV);
      check("reset instr", instr, 32'h0);
      check("reset instr_valid", {31'h0, instr_valid}, 32'h0);
      check("reset retire", {31'h0, retire}, 32'h0);
      check("reset instret", instret, 32'h0);
      check("reset halted", {31'h0, halted}, 32'h1);
      check("reset trap", {31'h0, trap}, 32'h0);
      check("reset trap_cause", {30'h0, trap_cause}, 32'h0);
      check("reset trap_pc", trap_pc, 32'h0);

      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle no req", {31'h0, imem_req}, 32'h0);
      check("idle halted", {31'h0, halted}, 32'h1);

      // en seen at the next edge: imem_req must be up right after it.
      en = 1'b1;
      @(negedge clk);
      check("req after en", {31'h0, imem_req}, 32'h1);
      check("running not halted", {31'h0, halted}, 32'h0);

      foreach (vecs[i]) begin
         do_fetch(vecs[i].addr, vecs[i].rdata, vecs[i].ack_dly);
         do_exec(vecs[i].new_pc, vecs[i].exec_dly, 1'b1, vecs[i].instret, vecs[i].rdata);
      end

      // Misaligned target from pc 0x20.
      do_fetch(32'h20, 32'h0020_8863, 0);
      do_exec(32'h22, 0, 1'b1, 32'h0, 32'h0020_8863);
      check("misalign trap", {31'h0, trap}, 32'h1);
      check("misalign cause", {30'h0, trap_cause}, 32'h1);
      check("misalign trap_pc", trap_pc, 32'h20);
      check("misalign halted", {31'h0, halted}, 32'h1);
      check("misalign pc kept", pc, 32'h20);
      check("misalign instret", instret, 32'd4);
      req_seen = 1'b0;
      repeat (22) begin
         @(negedge clk);
         if (imem_req) req_seen = 1'b1;
      end
      check("trap blocks fetch", {31'h0, req_seen}, 32'h0);
      check("trap sticky", {31'h0, trap}, 32'h1);
      do_reset();
      @(negedge clk);
      check("trap cleared", {31'h0, trap}, 32'h0);
      check("cause cleared", {30'h0, trap_cause}, 32'h0);
      check("trap_pc cleared", trap_pc, 32'h0);
      check("pc after reset", pc, RV);

      // Fetch timeout: 16 unacknowledged FETCH cycles.
      en = 1'b1;
      wait_req();
      repeat (15) @(negedge clk);
      check("req on 16th cycle", {31'h0, imem_req}, 32'h1);
      check("no trap before 16th edge", {31'h0, trap}, 32'h0);
      @(negedge clk);
      check("timeout trap", {31'h0, trap}, 32'h1);
      check("timeout cause", {30'h0, trap_cause}, 32'h2);
      check("timeout trap_pc", trap_pc, RV);
      check("timeout drops req", {31'h0, imem_req}, 32'h0);
      check("timeout halted", {31'h0, halted}, 32'h1);
      do_reset();

      // Ack arriving on the 16th cycle wins.
      en = 1'b1;
      do_fetch(RV, 32'h0040_0113, 15);
      check("ack on 16th no trap", {31'h0, trap}, 32'h0);
      do_exec(32'h4, 0, 1'b1, 32'd1, 32'h0040_0113);

      // Halt and resume: en dropped during EXEC.
      do_fetch(32'h4, 32'h0030_0193, 0);
      do_exec(32'h8, 1, 1'b0, 32'd2, 32'h0030_0193);
      check("halt state", {31'h0, halted}, 32'h1);
      check("halt no req", {31'h0, imem_req}, 32'h0);
      check("halt pc", pc, 32'h8);
      repeat (3) @(negedge clk);
      check("halt stays idle", {31'h0, imem_req}, 32'h0);

      // Counter wrap on the next retire.
      force dut.instret = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.instret;
      en = 1'b1;
      do_fetch(32'h8, 32'h0000_0073, 0);
      do_exec(32'hC, 0, 1'b1, 32'h0, 32'h0000_0073);

      // Reset mid-fetch, then a late ack must be ignored.
      wait_req();
      check("resume addr", imem_addr, 32'hC);
      rst_n = 1'b0;
      en    = 1'b0;
      @(negedge clk);
      check("mid-fetch reset req", {31'h0, imem_req}, 32'h0);
      check("mid-fetch reset pc", pc, RV);
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      check("late ack ignored instr", instr, 32'h0);
      check("late ack idle", {31'h0, halted}, 32'h1);
      check("late ack no req", {31'h0, imem_req}, 32'h0);

      repeat (2) @(negedge clk);
      check("dispatch queue drained", exp_instr_q.size(), 32'h0);
      check("retire queue drained", exp_ret_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
